// File: rtl/nonce_pkg.sv
// rtl/nonce_pkg.sv - shared defaults and parameter helpers for the nonce sequencer
package nonce_pkg;

    localparam int NONCE_W_DEF = 256;
    localparam int SEG_W_DEF   = 8;
    localparam int STEP_W_DEF  = 8;
    localparam int CNT_W_DEF   = 32;

    function automatic int nseg(input int nonce_w, input int seg_w);
        return nonce_w / seg_w;
    endfunction

    function automatic bit cfg_ok(input int nonce_w, input int seg_w, input int step_w);
        return (seg_w > 0) && (nonce_w >= seg_w) && (nonce_w % seg_w == 0) &&
               (step_w > 0) && (step_w <= seg_w);
    endfunction

endpackage

// File: rtl/nonce_seg_adder.sv
// rtl/nonce_seg_adder.sv - one segment of the split nonce carry chain
module nonce_seg_adder #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] seg_i,
    input  logic [SEG_W-1:0] addend_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, seg_i} + {1'b0, addend_i} + {{SEG_W{1'b0}}, cin_i};

endmodule

// File: rtl/nonce_sequencer.sv
// rtl/nonce_sequencer.sv - nonce generator with segmented, one-segment-per-cycle carry ripple
module nonce_sequencer
    import nonce_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int SEG_W   = SEG_W_DEF,
    parameter int STEP_W  = STEP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [NONCE_W-1:0] seed_i,
    input  logic [STEP_W-1:0]  step_i,
    output logic [NONCE_W-1:0] nonce_o,
    output logic               nonce_valid_o,
    input  logic               nonce_ready_i,
    output logic               busy_o,
    output logic               wrapped_o,
    output logic [CNT_W-1:0]   issued_cnt_o
);

    localparam int NSEG = nseg(NONCE_W, SEG_W);

    generate
        if (!cfg_ok(NONCE_W, SEG_W, STEP_W)) begin : g_cfg_err
            $error("nonce_sequencer: NONCE_W must be a multiple of SEG_W and STEP_W <= SEG_W");
        end
    endgenerate

    logic [NONCE_W-1:0] nonce_q, nonce_d;
    // Bit k flags a carry pending into segment k; bit 0 is never set.
    logic [NSEG-1:0]    carry_q, carry_d;
    logic [NSEG-1:0]    seg_cout;
    logic               armed_q;
    logic               wrapped_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fire;
    logic [SEG_W-1:0]   step_add;

    assign nonce_valid_o = armed_q & ~|carry_q;
    assign busy_o        = |carry_q;
    assign fire          = nonce_valid_o & nonce_ready_i;
    assign step_add      = fire ? SEG_W'(step_i) : '0;

    // Idle segments see addend 0 and no carry-in, so their sum equals the stored value.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        nonce_seg_adder #(.SEG_W(SEG_W)) u_add (
            .seg_i    (nonce_q[k*SEG_W +: SEG_W]),
            .addend_i ((k == 0) ? step_add : {SEG_W{1'b0}}),
            .cin_i    (carry_q[k]),
            .sum_o    (nonce_d[k*SEG_W +: SEG_W]),
            .cout_o   (seg_cout[k])
        );
    end

    always_comb begin
        carry_d = '0;
        for (int k = 1; k < NSEG; k++) begin
            carry_d[k] = seg_cout[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q   <= '0;
            carry_q   <= '0;
            armed_q   <= 1'b0;
            wrapped_q <= 1'b0;
            cnt_q     <= '0;
        end else if (load_i) begin
            nonce_q   <= seed_i;
            carry_q   <= '0;
            armed_q   <= 1'b1;
            wrapped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            nonce_q <= nonce_d;
            carry_q <= carry_d;
            if (seg_cout[NSEG-1]) begin
                wrapped_q <= 1'b1;
            end
            if (fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign nonce_o      = nonce_q;
    assign wrapped_o    = wrapped_q;
    assign issued_cnt_o = cnt_q;

endmodule

// File: tb/tb_nonce_sequencer.sv
// tb/tb_nonce_sequencer.sv - directed table-driven bench for nonce_sequencer
module tb_nonce_sequencer;

    localparam int NW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_i;
    logic [NW-1:0] seed_i;
    logic [7:0]    step_i;
    logic [NW-1:0] nonce_o;
    logic          nonce_valid_o;
    logic          nonce_ready_i;
    logic          busy_o;
    logic          wrapped_o;
    logic [31:0]   issued_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    nonce_sequencer #(.NONCE_W(NW), .SEG_W(8), .STEP_W(8), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load_i),
        .seed_i        (seed_i),
        .step_i        (step_i),
        .nonce_o       (nonce_o),
        .nonce_valid_o (nonce_valid_o),
        .nonce_ready_i (nonce_ready_i),
        .busy_o        (busy_o),
        .wrapped_o     (wrapped_o),
        .issued_cnt_o  (issued_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          load;
        logic [NW-1:0] seed;
        logic [7:0]    step;
        logic          ready;
        logic [NW-1:0] e_nonce;
        logic          e_valid;
        logic          e_busy;
        logic          e_wrap;
        logic [31:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [NW-1:0] sd, input logic [7:0] st, input logic rdy,
                       input logic [NW-1:0] en, input logic ev, input logic eb, input logic ew,
                       input logic [31:0] ec);
        vec_t v;
        v.load = ld; v.seed = sd; v.step = st; v.ready = rdy;
        v.e_nonce = en; v.e_valid = ev; v.e_busy = eb; v.e_wrap = ew; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic [NW-1:0] en, input logic ev,
                           input logic eb, input logic ew, input logic [31:0] ec);
        chk({tag, ".nonce"}, nonce_o, en);
        chk({tag, ".valid"}, 32'(nonce_valid_o), 32'(ev));
        chk({tag, ".busy"}, 32'(busy_o), 32'(eb));
        chk({tag, ".wrapped"}, 32'(wrapped_o), 32'(ew));
        chk({tag, ".cnt"}, issued_cnt_o, ec);
    endtask

    initial begin
        rst_n = 1'b0; load_i = 1'b0; seed_i = '0; step_i = 8'd0; nonce_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        // No load yet: valid must stay low even with ready high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_all($sformatf("unarmed%0d", i), 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        end

        //   load seed          step  rdy   nonce         v  b  w  cnt
        add(1, 32'h00000000, 8'd0, 0,   32'h00000000, 1, 0, 0, 0);
        add(0, 32'h0,        8'd1, 1,   32'h00000001, 1, 0, 0, 1);
        add(0, 32'h0,        8'd1, 1,   32'h00000002, 1, 0, 0, 2);
        add(0, 32'h0,        8'd1, 1,   32'h00000003, 1, 0, 0, 3);
        add(0, 32'h0,        8'd1, 1,   32'h00000004, 1, 0, 0, 4);
        add(0, 32'h0,        8'd9, 0,   32'h00000004, 1, 0, 0, 4);
        add(1, 32'h000000FF, 8'd0, 0,   32'h000000FF, 1, 0, 0, 0);
        add(0, 32'h0,        8'd1, 1,   32'h00000000, 0, 1, 0, 1);
        add(0, 32'h0,        8'd1, 1,   32'h00000100, 1, 0, 0, 1);
        add(1, 32'h00FFFFFF, 8'd0, 0,   32'h00FFFFFF, 1, 0, 0, 0);
        add(0, 32'h0,        8'd1, 1,   32'h00FFFF00, 0, 1, 0, 1);
        add(0, 32'h0,        8'd1, 1,   32'h00FF0000, 0, 1, 0, 1);
        add(0, 32'h0,        8'd1, 1,   32'h00000000, 0, 1, 0, 1);
        add(0, 32'h0,        8'd1, 0,   32'h01000000, 1, 0, 0, 1);
        add(1, 32'hFFFFFFFF, 8'd0, 0,   32'hFFFFFFFF, 1, 0, 0, 0);
        add(0, 32'h0,        8'd2, 1,   32'hFFFFFF01, 0, 1, 0, 1);
        add(0, 32'h0,        8'd2, 0,   32'hFFFF0001, 0, 1, 0, 1);
        add(0, 32'h0,        8'd2, 0,   32'hFF000001, 0, 1, 0, 1);
        add(0, 32'h0,        8'd2, 0,   32'h00000001, 1, 0, 1, 1);
        add(0, 32'h0,        8'd3, 1,   32'h00000004, 1, 0, 1, 2);
        add(0, 32'h0,        8'd0, 1,   32'h00000004, 1, 0, 1, 3);
        add(1, 32'h00FFFFFF, 8'd1, 1,   32'h00FFFFFF, 1, 0, 0, 0);
        add(0, 32'h0,        8'd1, 1,   32'h00FFFF00, 0, 1, 0, 1);
        add(1, 32'h12345678, 8'd0, 0,   32'h12345678, 1, 0, 0, 0);
        add(0, 32'h0,        8'h80, 1,  32'h123456F8, 1, 0, 0, 1);
        add(0, 32'h0,        8'h88, 1,  32'h12345680, 0, 1, 0, 2);
        add(0, 32'h0,        8'd0, 0,   32'h12345780, 1, 0, 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            load_i = vecs[i].load; seed_i = vecs[i].seed;
            step_i = vecs[i].step; nonce_ready_i = vecs[i].ready;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_nonce, vecs[i].e_valid,
                    vecs[i].e_busy, vecs[i].e_wrap, vecs[i].e_cnt);
        end

        // Mid-ripple async reset: outputs clear before the next clock edge.
        load_i = 1'b1; seed_i = 32'h00FFFFFF; nonce_ready_i = 1'b0;
        @(posedge clk); #1;
        load_i = 1'b0; step_i = 8'd1; nonce_ready_i = 1'b1;
        @(posedge clk); #2;
        chk("pre_rst.busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("post_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
